i2c_scl_gen: RTL and testbench

//   Parametrised I2C SCL generator. Replaces the fixed 400 kHz clk_gen.

---
 rtl/i2c_scl_gen.sv | 154 +++++++++++++++
 tb/tb_i2c_scl_gen.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_scl_gen.sv
// i2c_scl_gen: I2C SCL generator with standard/fast mode select, run/stop
// control, slave clock-stretch detection with timeout, and single-cycle phase
// strobes for SDA drive/sample timing. The pad is SCL = scl_t ? 1'bZ : 1'b0.
//
// Ports:
//   CLK        system clock
//   RST        asynchronous reset, active-high
//   en         run request; 0 lets the current period finish and parks SCL high
//   mode       0 = standard, 1 = fast; sampled only when leaving IDLE
//   scl_i      SCL pad input (asynchronous, synchronised internally)
//   scl_t      pad tristate: 1 = release, 0 = drive low (registered)
//   busy       state is not IDLE
//   tick_fall  strobe on the cycle scl_t goes low
//   tick_lmid  strobe at mid-low (SDA change point)
//   tick_rise  strobe when synchronised SCL is first seen high
//   tick_hmid  strobe at mid-high (SDA sample point)
//   stretch    SCL released but still held low by a slave beyond SYNC cycles
//   timeout    sticky: stretch lasted TO_CYCLES; cleared while en = 0
module i2c_scl_gen #(
  parameter int unsigned HALF_FAST = 195,
  parameter int unsigned HALF_STD  = 781,
  parameter int unsigned CNT_W     = 11,
  parameter int unsigned SYNC      = 2,
  parameter int unsigned TO_CYCLES = 15625
) (
  input  logic CLK,
  input  logic RST,
  input  logic en,
  input  logic mode,
  input  logic scl_i,
  output logic scl_t,
  output logic busy,
  output logic tick_fall,
  output logic tick_lmid,
  output logic tick_rise,
  output logic tick_hmid,
  output logic stretch,
  output logic timeout
);

  localparam int unsigned WAIT_W = $clog2(TO_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOW       = 2'd1,
    HIGH_WAIT = 2'd2,
    HIGH      = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  half;
  logic [CNT_W-1:0]  mid;
  logic [CNT_W-1:0]  cnt_inc;
  logic              cnt_last;
  logic [WAIT_W-1:0] wcnt;
  logic [SYNC-1:0]   sync_q;
  logic              scl_s;

  always_comb begin
    mid      = half >> 1;
    cnt_inc  = cnt + CNT_W'(1);
    cnt_last = (cnt == half - CNT_W'(1));
    scl_s    = sync_q[SYNC-1];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], scl_i};
    end
  end

  always_comb begin
    busy      = (state != IDLE);
    tick_rise = (state == HIGH_WAIT) && scl_s;
    stretch   = (state == HIGH_WAIT) && (wcnt >= WAIT_W'(SYNC)) && !scl_s;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      scl_t     <= 1'b1;
      cnt       <= '0;
      wcnt      <= '0;
      half      <= CNT_W'(HALF_STD);
      tick_fall <= 1'b0;
      tick_lmid <= 1'b0;
      tick_hmid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      tick_fall <= 1'b0;
      tick_lmid <= 1'b0;
      tick_hmid <= 1'b0;
      case (state)
        IDLE: begin
          scl_t <= 1'b1;
          if (!en) begin
            timeout <= 1'b0;
          end else if (!timeout) begin
            half      <= mode ? CNT_W'(HALF_FAST) : CNT_W'(HALF_STD);
            cnt       <= '0;
            state     <= LOW;
            scl_t     <= 1'b0;
            tick_fall <= 1'b1;
          end
        end
        LOW: begin
          if (cnt_last) begin
            state <= HIGH_WAIT;
            scl_t <= 1'b1;
            cnt   <= '0;
            wcnt  <= '0;
          end else begin
            cnt       <= cnt_inc;
            tick_lmid <= (cnt_inc == mid);
          end
        end
        HIGH_WAIT: begin
          if (scl_s) begin
            // Counter restarts at the number of cycles since the pad actually
            // rose (SYNC flops plus this detection cycle), so the high phase
            // measured at the pad is exactly half.
            state <= HIGH;
            cnt   <= CNT_W'(SYNC + 1);
          end else if (wcnt == WAIT_W'(TO_CYCLES - 1)) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            wcnt <= wcnt + WAIT_W'(1);
          end
        end
        HIGH: begin
          if (cnt_last) begin
            if (en) begin
              state     <= LOW;
              scl_t     <= 1'b0;
              tick_fall <= 1'b1;
              cnt       <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt       <= cnt_inc;
            tick_hmid <= (cnt_inc == mid);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_scl_gen.sv
// tb_i2c_scl_gen: directed bench for i2c_scl_gen. The pad is modelled as
// open-drain: scl_i follows scl_t unless a slave model holds it low for a
// programmed number of cycles after each release, or it is stuck low.
module tb_i2c_scl_gen;

  logic CLK = 1'b0;
  logic RST;
  logic en;
  logic mode;
  logic scl_i;
  logic scl_t;
  logic busy;
  logic tick_fall;
  logic tick_lmid;
  logic tick_rise;
  logic tick_hmid;
  logic stretch;
  logic timeout;

  always #5 CLK = ~CLK;

  i2c_scl_gen #(
    .HALF_FAST(195),
    .HALF_STD (781),
    .CNT_W    (11),
    .SYNC     (2),
    .TO_CYCLES(15625)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .en       (en),
    .mode     (mode),
    .scl_i    (scl_i),
    .scl_t    (scl_t),
    .busy     (busy),
    .tick_fall(tick_fall),
    .tick_lmid(tick_lmid),
    .tick_rise(tick_rise),
    .tick_hmid(tick_hmid),
    .stretch  (stretch),
    .timeout  (timeout)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Event timestamps (cycle index) collected at the falling edge.
  int fall_q[$];
  int lmid_q[$];
  int rise_q[$];
  int hmid_q[$];
  int up_q[$];
  int dn_q[$];
  int str_q[$];
  int to_q[$];

  logic prev_t    = 1'b1;
  logic prev_str  = 1'b0;
  logic prev_to   = 1'b0;
  int   excl_bad  = 0;
  int   hold_n    = 0;
  int   hold_cnt  = 0;
  logic hold_low  = 1'b0;
  logic stuck     = 1'b0;

  always_comb scl_i = scl_t && !hold_low && !stuck;

  always @(negedge CLK) begin
    if (tick_fall) fall_q.push_back(cyc);
    if (tick_lmid) lmid_q.push_back(cyc);
    if (tick_rise) rise_q.push_back(cyc);
    if (tick_hmid) hmid_q.push_back(cyc);
    if (scl_t && !prev_t) up_q.push_back(cyc);
    if (!scl_t && prev_t) dn_q.push_back(cyc);
    if (stretch && !prev_str) str_q.push_back(cyc);
    if (timeout && !prev_to) to_q.push_back(cyc);
    if (int'(tick_fall) + int'(tick_lmid) + int'(tick_rise) + int'(tick_hmid) > 1)
      excl_bad++;
    // Slave model: holds the line low for hold_n cycles after each release.
    if (scl_t && !prev_t && hold_n > 0) begin
      hold_low = 1'b1;
      hold_cnt = hold_n;
    end else if (hold_low) begin
      hold_cnt--;
      if (hold_cnt == 0) hold_low = 1'b0;
    end
    prev_t   = scl_t;
    prev_str = stretch;
    prev_to  = timeout;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic clear_q();
    fall_q.delete();
    lmid_q.delete();
    rise_q.delete();
    hmid_q.delete();
    up_q.delete();
    dn_q.delete();
    str_q.delete();
    to_q.delete();
  endtask

  task automatic wait_idle(input string name);
    for (int n = 0; n < 5000 && busy; n++) tick();
    chk(name, int'(busy), 0);
  endtask

  typedef struct {
    bit mode;
    int hold;
    int low;
    int high;
    int period;
    int lmid;
    int rise;
    int hmid;
    int str_off;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int c0;
    string p;

    // mode, slave hold, low, high, period, lmid-fall, rise-release,
    // hmid-release, first stretch-release (-1 = never)
    vecs[0] = '{1'b1,   0, 195, 195,  390,  97,   2,  97, -1};
    vecs[1] = '{1'b0,   0, 781, 781, 1562, 390,   2, 390, -1};
    vecs[2] = '{1'b1, 500, 195, 695,  890,  97, 502, 597,  2};
    vecs[3] = '{1'b0, 100, 781, 881, 1662, 390, 102, 490,  2};

    RST  = 1'b1;
    en   = 1'b0;
    mode = 1'b0;
    tick();
    tick();
    chk("rst scl_t", int'(scl_t), 1);
    chk("rst busy", int'(busy), 0);
    chk("rst ticks", int'(tick_fall) + int'(tick_lmid) + int'(tick_rise) + int'(tick_hmid), 0);
    chk("rst stretch", int'(stretch), 0);
    chk("rst timeout", int'(timeout), 0);
    RST = 1'b0;
    tick();
    chk("idle scl_t", int'(scl_t), 1);

    for (int v = 0; v < 4; v++) begin
      p = $sformatf("v%0d", v);
      clear_q();
      hold_n = vecs[v].hold;
      mode   = vecs[v].mode;
      tick();
      en = 1'b1;
      c0 = cyc;
      for (int n = 0; n < 12000 && fall_q.size() < 3; n++) tick();
      chk({p, " falls"}, fall_q.size(), 3);
      en = 1'b0;
      wait_idle({p, " stop busy"});
      chk({p, " stop scl_t"}, int'(scl_t), 1);
      chk({p, " no extra fall"}, fall_q.size(), 3);
      chk({p, " timeout"}, int'(timeout), 0);
      if (fall_q.size() == 3 && dn_q.size() >= 2 && up_q.size() >= 1 &&
          lmid_q.size() >= 1 && rise_q.size() >= 1 && hmid_q.size() >= 1) begin
        chk({p, " latency"}, fall_q[0] - c0, 1);
        chk({p, " fall align"}, dn_q[0] - fall_q[0], 0);
        chk({p, " period1"}, fall_q[1] - fall_q[0], vecs[v].period);
        chk({p, " period2"}, fall_q[2] - fall_q[1], vecs[v].period);
        chk({p, " low"}, up_q[0] - dn_q[0], vecs[v].low);
        chk({p, " high"}, dn_q[1] - up_q[0], vecs[v].high);
        chk({p, " lmid"}, lmid_q[0] - fall_q[0], vecs[v].lmid);
        chk({p, " rise"}, rise_q[0] - up_q[0], vecs[v].rise);
        chk({p, " hmid"}, hmid_q[0] - up_q[0], vecs[v].hmid);
        chk({p, " stretch"}, (str_q.size() > 0) ? str_q[0] - up_q[0] : -1, vecs[v].str_off);
      end
    end

    // Mode change while busy is ignored, then async reset mid-LOW.
    clear_q();
    hold_n = 0;
    mode   = 1'b1;
    tick();
    en = 1'b1;
    for (int n = 0; n < 10 && fall_q.size() < 1; n++) tick();
    mode = 1'b0;
    for (int n = 0; n < 2000 && fall_q.size() < 2; n++) tick();
    chk("modeflip falls", fall_q.size(), 2);
    if (fall_q.size() == 2) chk("modeflip period", fall_q[1] - fall_q[0], 390);
    for (int n = 0; n < 50; n++) tick();
    chk("prerst scl_t", int'(scl_t), 0);
    #1 RST = 1'b1;
    #1;
    chk("async rst scl_t", int'(scl_t), 1);
    chk("async rst busy", int'(busy), 0);
    chk("async rst ticks", int'(tick_fall) + int'(tick_lmid) + int'(tick_rise) + int'(tick_hmid), 0);
    tick();
    chk("held rst scl_t", int'(scl_t), 1);
    RST = 1'b0;
    tick();
    chk("post rst tick_fall", int'(tick_fall), 1);
    chk("post rst scl_t", int'(scl_t), 0);
    en = 1'b0;
    wait_idle("post rst stop");

    // Stuck-low SCL: timeout, no restart while en stays high, recovery.
    clear_q();
    mode = 1'b1;
    tick();
    en    = 1'b1;
    stuck = 1'b1;
    for (int n = 0; n < 17000 && to_q.size() < 1; n++) tick();
    chk("to seen", to_q.size(), 1);
    if (to_q.size() == 1 && up_q.size() >= 1) chk("to delay", to_q[0] - up_q[0], 15625);
    chk("to busy", int'(busy), 0);
    chk("to scl_t", int'(scl_t), 1);
    chk("to stretch", int'(stretch), 0);
    for (int n = 0; n < 20; n++) tick();
    chk("to no restart", fall_q.size(), 1);
    chk("to sticky", int'(timeout), 1);
    stuck = 1'b0;
    en    = 1'b0;
    tick();
    chk("to cleared", int'(timeout), 0);
    en = 1'b1;
    tick();
    chk("to resume fall", int'(tick_fall), 1);
    en = 1'b0;
    wait_idle("to resume stop");

    chk("tick exclusive", excl_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog: got running want finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
